// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative unsigned multiply/divide, one result bit per cycle.
// Holds the front of the pipe via freeze while an operation is in flight.
module ex_muldiv_unit #(
  parameter int unsigned WIDTH   = 32,
  parameter logic [3:0]  CMD_MUL = 4'b1100,
  parameter logic [3:0]  CMD_DIV = 4'b1101
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       ex_cmd,
  input  logic [WIDTH-1:0] val1,
  input  logic [WIDTH-1:0] val2,
  input  logic [4:0]       dst,
  input  logic             wb_en_in,
  input  logic             flush,
  output logic             freeze,
  output logic             busy,
  output logic             result_valid,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [4:0]       dst_out,
  output logic             wb_en_out
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t             state;
  logic [CW-1:0]      counter;
  logic               op_div;
  logic [WIDTH-1:0]   opb;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [4:0]         dst_q;
  logic               wb_en_q;
  logic               wb_en_r;
  logic               start;
  logic               last;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     trial;

  // acc is {hi, lo}: product accumulator for MUL, {remainder, quotient} for DIV.
  always_comb begin
    start    = rst && (state == IDLE) && ((ex_cmd == CMD_MUL) || (ex_cmd == CMD_DIV)) && !flush;
    last     = (counter == CW'(WIDTH - 1));
    addend   = acc[0] ? opb : '0;
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
    shifted  = acc[2*WIDTH-1:WIDTH-1];
    trial    = shifted - {1'b0, opb};
    acc_next = acc;
    if (op_div) begin
      if (!trial[WIDTH])
        acc_next = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else
        acc_next = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      acc_next = {sum, acc[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      counter <= '0;
      op_div  <= 1'b0;
      opb     <= '0;
      acc     <= '0;
      dst_q   <= '0;
      wb_en_q <= 1'b0;
      wb_en_r <= 1'b0;
      result  <= '0;
      hi      <= '0;
      dst_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= BUSY;
            counter <= '0;
            op_div  <= (ex_cmd == CMD_DIV);
            opb     <= (ex_cmd == CMD_DIV) ? val2 : val1;
            acc     <= (ex_cmd == CMD_DIV) ? {{WIDTH{1'b0}}, val1} : {{WIDTH{1'b0}}, val2};
            dst_q   <= dst;
            wb_en_q <= wb_en_in;
          end
        end
        BUSY: begin
          acc     <= acc_next;
          counter <= counter + 1'b1;
          if (last) begin
            state   <= DONE;
            result  <= acc_next[WIDTH-1:0];
            hi      <= acc_next[2*WIDTH-1:WIDTH];
            dst_out <= dst_q;
            wb_en_r <= wb_en_q;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy         = (state == BUSY);
  assign result_valid = (state == DONE);
  assign freeze       = start || busy;
  assign wb_en_out    = wb_en_r & result_valid;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: cycle-level arithmetic model plus literal checks.
module tb_ex_muldiv_unit;

  localparam int unsigned W   = 32;
  localparam logic [3:0]  MUL = 4'b1100;
  localparam logic [3:0]  DIV = 4'b1101;
  localparam logic [3:0]  NOP = 4'b0000;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [3:0]    ex_cmd = NOP;
  logic [W-1:0]  val1 = '0;
  logic [W-1:0]  val2 = '0;
  logic [4:0]    dst = '0;
  logic          wb_en_in = 1'b0;
  logic          flush = 1'b0;
  logic          freeze, busy, result_valid, wb_en_out;
  logic [W-1:0]  result, hi;
  logic [4:0]    dst_out;

  ex_muldiv_unit #(.WIDTH(W), .CMD_MUL(MUL), .CMD_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .ex_cmd(ex_cmd), .val1(val1), .val2(val2),
    .dst(dst), .wb_en_in(wb_en_in), .flush(flush),
    .freeze(freeze), .busy(busy), .result_valid(result_valid),
    .result(result), .hi(hi), .dst_out(dst_out), .wb_en_out(wb_en_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Model: an op accepted in IDLE completes exactly W+1 cycles later.
  int           cyc = 0;
  int           done_cyc = 0;
  logic         in_flight = 1'b0;
  logic         exp_rv, exp_fz, exp_busy, s;
  logic [W-1:0] m_res = '0, m_hi = '0, p_res = '0, p_hi = '0;
  logic [4:0]   m_dst = '0, p_dst = '0;
  logic         m_wb = 1'b0, p_wb = 1'b0;
  logic [63:0]  prod;

  always @(negedge clk) begin
    cyc++;
    exp_rv = 1'b0; exp_fz = 1'b0; exp_busy = 1'b0;
    if (!rst) begin
      in_flight = 1'b0;
      m_res = '0; m_hi = '0; m_dst = '0; m_wb = 1'b0;
    end else if (in_flight) begin
      if (cyc == done_cyc) begin
        in_flight = 1'b0;
        exp_rv = 1'b1;
        m_res = p_res; m_hi = p_hi; m_dst = p_dst; m_wb = p_wb;
      end else begin
        exp_fz = 1'b1; exp_busy = 1'b1;
      end
    end else begin
      s = ((ex_cmd == MUL) || (ex_cmd == DIV)) && !flush;
      exp_fz = s;
      if (s) begin
        in_flight = 1'b1;
        done_cyc = cyc + W + 1;
        p_dst = dst; p_wb = wb_en_in;
        if (ex_cmd == MUL) begin
          prod  = {32'd0, val1} * {32'd0, val2};
          p_res = prod[31:0];
          p_hi  = prod[63:32];
        end else if (val2 == 0) begin
          p_res = '1;
          p_hi  = val1;
        end else begin
          p_res = val1 / val2;
          p_hi  = val1 % val2;
        end
      end
    end
    check("m_freeze", freeze, exp_fz);
    check("m_busy", busy, exp_busy);
    check("m_result_valid", result_valid, exp_rv);
    check("m_result", result, m_res);
    check("m_hi", hi, m_hi);
    check("m_dst_out", dst_out, m_dst);
    check("m_wb_en_out", wb_en_out, m_wb & exp_rv);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] cmd, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [4:0] d, input logic wb, input int flush_at,
                       output logic [W-1:0] r, output logic [W-1:0] h, output logic [4:0] dd,
                       output logic wo, output int n, output int fz, output time t);
    tick();
    ex_cmd = cmd; val1 = a; val2 = b; dst = d; wb_en_in = wb; flush = 1'b0;
    r = '0; h = '0; dd = '0; wo = 1'b0; n = -1; fz = 0; t = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (result_valid) begin
        n = i; r = result; h = hi; dd = dst_out; wo = wb_en_out; t = $time;
        break;
      end
      if (freeze) fz++;
      if (i == flush_at) begin #1 flush = 1'b1; end
      if (i == flush_at + 1) begin #1 flush = 1'b0; end
    end
    if (n < 0) check("result_valid_timeout", 0, 1);
  endtask

  logic [W-1:0] r, h;
  logic [4:0]   dd;
  logic         wo;
  int           n, fz;
  time          t1, t2;

  initial begin
    repeat (2) tick();
    check("reset_freeze", freeze, 0);
    check("reset_result", result, 0);
    rst = 1'b1;
    tick();

    issue(MUL, 7, 6, 5'd5, 1'b1, -10, r, h, dd, wo, n, fz, t1);
    check("mul7x6_latency", n, 33);
    check("mul7x6_freeze_cycles", fz, 33);
    check("mul7x6_result", r, 42);
    check("mul7x6_hi", h, 0);
    check("mul7x6_dst", dd, 5);
    check("mul7x6_wb", wo, 1);

    issue(MUL, 32'hFFFF_FFFF, 2, 5'd3, 1'b0, -10, r, h, dd, wo, n, fz, t1);
    check("mulmax_result", r, 32'hFFFF_FFFE);
    check("mulmax_hi", h, 32'h0000_0001);
    check("mulmax_wb", wo, 0);

    issue(DIV, 100, 7, 5'd9, 1'b1, -10, r, h, dd, wo, n, fz, t1);
    check("div100_7_q", r, 14);
    check("div100_7_r", h, 2);
    issue(DIV, 5, 0, 5'd10, 1'b1, -10, r, h, dd, wo, n, fz, t1);
    check("div5_0_q", r, 32'hFFFF_FFFF);
    check("div5_0_r", h, 5);
    check("div5_0_dst", dd, 10);

    tick();
    ex_cmd = MUL; val1 = 9; val2 = 9; flush = 1'b1;
    #1 check("flush_idle_freeze", freeze, 0);
    repeat (3) begin
      tick();
      check("flush_idle_busy", busy, 0);
      check("flush_idle_rv", result_valid, 0);
    end
    tick();
    flush = 1'b0; ex_cmd = NOP;

    issue(MUL, 11, 13, 5'd4, 1'b1, 5, r, h, dd, wo, n, fz, t1);
    check("flush_busy_latency", n, 33);
    check("flush_busy_result", r, 143);

    tick();
    ex_cmd = MUL; val1 = 5; val2 = 5; dst = 5'd7; wb_en_in = 1'b1;
    repeat (10) tick();
    #2 rst = 1'b0;
    #1;
    check("rst_busy_freeze", freeze, 0);
    check("rst_busy_busy", busy, 0);
    check("rst_busy_result", result, 0);
    check("rst_busy_dst", dst_out, 0);
    ex_cmd = NOP;
    repeat (2) tick();
    rst = 1'b1;
    repeat (3) tick();
    check("post_rst_idle_rv", result_valid, 0);
    issue(MUL, 3, 3, 5'd2, 1'b1, -10, r, h, dd, wo, n, fz, t1);
    check("post_rst_mul3x3", r, 9);

    tick();
    ex_cmd = NOP;
    issue(DIV, 100, 7, 5'd1, 1'b1, -10, r, h, dd, wo, n, fz, t1);
    check("b2b_first", r, 14);
    issue(MUL, 3, 4, 5'd2, 1'b1, -10, r, h, dd, wo, n, fz, t2);
    check("b2b_second", r, 12);
    check("b2b_spacing", (t2 - t1) / 10, 34);

    tick();
    ex_cmd = NOP;
    repeat (5) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
